// File: rtl/mem_stage_pkg.sv
// Shared encodings, FSM state type and store-lane helpers for the memory stage.
package mem_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] MEM_BYTE  = 3'b000;
  localparam logic [2:0] MEM_HALF  = 3'b001;
  localparam logic [2:0] MEM_WORD  = 3'b010;
  localparam logic [2:0] MEM_BYTEU = 3'b100;
  localparam logic [2:0] MEM_HALFU = 3'b101;

  localparam logic [XLEN-1:0] MEM_ERR_VAL = 32'hbaad_beef;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Access captured in IDLE and held stable for the whole BUSY phase.
  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      funct3;
    logic [1:0]      offset;
  } mem_req_t;

  // funct3[1:0] encodes size; the unused 2'b11 size is handled as a word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = offset[0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

  function automatic logic [BE_W-1:0] store_be(input logic [2:0] funct3, input logic [1:0] offset);
    logic [BE_W-1:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] funct3, input logic [XLEN-1:0] regb);
    logic [XLEN-1:0] d;
    case (funct3[1:0])
      2'b00:   d = {4{regb[7:0]}};
      2'b01:   d = {2{regb[15:0]}};
      default: d = regb;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Processor <-> data-memory req/ack handshake bundle.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic            proc2mem_req;
  logic            proc2mem_we;
  logic [XLEN-1:0] proc2mem_addr;
  logic [XLEN-1:0] proc2mem_data;
  logic [BE_W-1:0] proc2mem_be;
  logic            mem2proc_ack;
  logic [XLEN-1:0] mem2proc_data;

  modport master (
    output proc2mem_req, proc2mem_we, proc2mem_addr, proc2mem_data, proc2mem_be,
    input  mem2proc_ack, mem2proc_data
  );

  modport slave (
    input  proc2mem_req, proc2mem_we, proc2mem_addr, proc2mem_data, proc2mem_be,
    output mem2proc_ack, mem2proc_data
  );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (offset)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];

    result_c = word;
    case (funct3)
      MEM_BYTE:  result_c = {{24{lane_b[7]}}, lane_b};
      MEM_BYTEU: result_c = {24'h0, lane_b};
      MEM_HALF:  result_c = {{16{lane_h[15]}}, lane_h};
      MEM_HALFU: result_c = {16'h0, lane_h};
      default:   result_c = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory handshake, aligns load data and
// stalls upstream while an access is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] ex_mem_regb,
  input  logic [2:0]      ex_mem_funct3,
  input  logic            ex_mem_rd_mem,
  input  logic            ex_mem_wr_mem,
  input  logic            ex_mem_valid_inst,
  mem_stage_if.master     dmem,
  output logic [XLEN-1:0] mem_result_out,
  output logic            mem_stall_out,
  output logic            mem_misaligned_out,
  output logic            mem_err_out
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  mem_state_e      state;
  logic [CNT_W-1:0] cnt;
  mem_req_t        req_q;
  logic [XLEN-1:0] result_q;
  logic            err_q;

  logic            mem_op;
  logic            misaligned;
  logic [XLEN-1:0] load_val;

  assign mem_op     = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);
  assign misaligned = is_misaligned(ex_mem_funct3, ex_mem_alu_result[1:0]);

  mem_load_align u_load_align (
    .word     (dmem.mem2proc_data),
    .offset   (req_q.offset),
    .funct3   (req_q.funct3),
    .result_c (load_val)
  );

  // State, latched access and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      req_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op && !misaligned) begin
            // A load wins when both rd and wr are flagged.
            req_q.we     <= ex_mem_wr_mem & ~ex_mem_rd_mem;
            req_q.be     <= store_be(ex_mem_funct3, ex_mem_alu_result[1:0]);
            req_q.addr   <= {ex_mem_alu_result[XLEN-1:2], 2'b00};
            req_q.data   <= store_data(ex_mem_funct3, ex_mem_regb);
            req_q.funct3 <= ex_mem_funct3;
            req_q.offset <= ex_mem_alu_result[1:0];
            cnt          <= '0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (dmem.mem2proc_ack) begin
            result_q <= req_q.we ? '0 : load_val;
            state    <= DONE;
          end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            result_q <= MEM_ERR_VAL;
            err_q    <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pass-through, misalignment and stall are resolved in the same cycle in IDLE.
  always_comb begin
    mem_result_out     = '0;
    mem_stall_out      = 1'b0;
    mem_misaligned_out = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          mem_misaligned_out = misaligned;
          mem_stall_out      = ~misaligned;
        end else begin
          mem_result_out = ex_mem_alu_result;
        end
      end
      BUSY:    mem_stall_out  = 1'b1;
      DONE:    mem_result_out = result_q;
      default: ;
    endcase
  end

  assign dmem.proc2mem_req  = (state == BUSY);
  assign dmem.proc2mem_we   = req_q.we;
  assign dmem.proc2mem_addr = req_q.addr;
  assign dmem.proc2mem_data = req_q.data;
  assign dmem.proc2mem_be   = req_q.be;
  assign mem_err_out        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset-in-flight sequence and
// randomized accesses against an arithmetic reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned TMO = 16;

  logic        clk;
  logic        rst;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_regb;
  logic [2:0]  ex_mem_funct3;
  logic        ex_mem_rd_mem;
  logic        ex_mem_wr_mem;
  logic        ex_mem_valid_inst;
  logic [31:0] mem_result_out;
  logic        mem_stall_out;
  logic        mem_misaligned_out;
  logic        mem_err_out;

  mem_stage_if mem_if ();

  mem_stage #(.MEM_TIMEOUT(TMO)) dut (
    .clk                (clk),
    .rst                (rst),
    .ex_mem_alu_result  (ex_mem_alu_result),
    .ex_mem_regb        (ex_mem_regb),
    .ex_mem_funct3      (ex_mem_funct3),
    .ex_mem_rd_mem      (ex_mem_rd_mem),
    .ex_mem_wr_mem      (ex_mem_wr_mem),
    .ex_mem_valid_inst  (ex_mem_valid_inst),
    .dmem               (mem_if),
    .mem_result_out     (mem_result_out),
    .mem_stall_out      (mem_stall_out),
    .mem_misaligned_out (mem_misaligned_out),
    .mem_err_out        (mem_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] regb;
    logic [2:0]  f3;
    logic        rd;
    logic        wr;
    logic        valid;
    int          ack_delay;
    logic [31:0] word;
    logic [31:0] exp_result;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: access size in bytes from funct3.
  function automatic int unsigned m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic m_mis(input logic [31:0] addr, input logic [2:0] f3);
    return (addr % m_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] addr,
                                         input logic [2:0] f3);
    logic [31:0] v;
    v = word >> ((addr % 4) * 8);
    case (f3)
      3'b000: begin v = v % 256;   if (v >= 128)   v = v - 32'd256;   end
      3'b001: begin v = v % 65536; if (v >= 32768) v = v - 32'd65536; end
      3'b100: v = v % 256;
      3'b101: v = v % 65536;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [2:0] f3);
    int unsigned sz;
    int unsigned mask;
    sz   = m_size(f3);
    mask = ((1 << sz) - 1) << (addr % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] regb, input logic [2:0] f3);
    int unsigned sz;
    logic [31:0] lane;
    logic [31:0] d;
    sz   = m_size(f3);
    lane = (sz == 4) ? regb : (regb % (32'd1 << (8 * sz)));
    d    = 32'd0;
    for (int i = 0; i < 4 / sz; i++) d = d | (lane << (8 * sz * i));
    return d;
  endfunction

  task automatic set_idle(input logic [31:0] alu);
    ex_mem_alu_result = alu;
    ex_mem_regb       = $urandom;
    ex_mem_funct3     = 3'b000;
    ex_mem_rd_mem     = 1'b0;
    ex_mem_wr_mem     = 1'b0;
    ex_mem_valid_inst = 1'b0;
  endtask

  // Applies one instruction starting in IDLE and checks it through DONE.
  task automatic do_access(input string tag, input vec_t v);
    logic        mem_op;
    logic        is_store;
    int          busy_n;
    int          exp_busy;
    logic        tmo;
    logic [31:0] exp_res;
    logic [31:0] nxt;

    mem_op   = v.valid & (v.rd | v.wr);
    is_store = v.wr & ~v.rd;
    tmo      = (v.ack_delay >= int'(TMO));
    exp_busy = tmo ? int'(TMO) : v.ack_delay + 1;
    exp_res  = tmo ? 32'hbaad_beef : v.exp_result;

    ex_mem_alu_result = v.addr;
    ex_mem_regb       = v.regb;
    ex_mem_funct3     = v.f3;
    ex_mem_rd_mem     = v.rd;
    ex_mem_wr_mem     = v.wr;
    ex_mem_valid_inst = v.valid;
    #1;

    if (!mem_op || v.exp_mis) begin
      chk({tag, ".result"}, mem_result_out, v.exp_mis ? 32'h0 : v.exp_result);
      chk({tag, ".stall"}, mem_stall_out, 1'b0);
      chk({tag, ".mis"}, mem_misaligned_out, v.exp_mis);
      chk({tag, ".req"}, mem_if.proc2mem_req, 1'b0);
      mem_if.mem2proc_ack = 1'b1;
      step();
      mem_if.mem2proc_ack = 1'b0;
      nxt = $urandom;
      set_idle(nxt);
      #1;
      chk({tag, ".req_after"}, mem_if.proc2mem_req, 1'b0);
      chk({tag, ".pass_after"}, mem_result_out, nxt);
      return;
    end

    chk({tag, ".issue_stall"}, mem_stall_out, 1'b1);
    chk({tag, ".issue_mis"}, mem_misaligned_out, 1'b0);
    chk({tag, ".issue_req"}, mem_if.proc2mem_req, 1'b0);
    step();

    busy_n = 0;
    while (mem_if.proc2mem_req === 1'b1 && busy_n < int'(TMO) + 4) begin
      chk({tag, ".addr"}, mem_if.proc2mem_addr, {v.addr[31:2], 2'b00});
      chk({tag, ".busy_stall"}, mem_stall_out, 1'b1);
      if (busy_n == 0) begin
        chk({tag, ".we"}, mem_if.proc2mem_we, is_store);
        if (is_store) begin
          chk({tag, ".be"}, mem_if.proc2mem_be, v.exp_be);
          chk({tag, ".data"}, mem_if.proc2mem_data, v.exp_data);
        end
      end
      if (busy_n == v.ack_delay) begin
        mem_if.mem2proc_ack  = 1'b1;
        mem_if.mem2proc_data = v.word;
      end
      step();
      mem_if.mem2proc_ack  = 1'b0;
      mem_if.mem2proc_data = $urandom;
      busy_n++;
    end
    chk({tag, ".busy_cycles"}, busy_n, exp_busy);

    chk({tag, ".done_result"}, mem_result_out, exp_res);
    chk({tag, ".done_stall"}, mem_stall_out, 1'b0);
    chk({tag, ".done_req"}, mem_if.proc2mem_req, 1'b0);
    chk({tag, ".done_err"}, mem_err_out, tmo);
    step();

    nxt = $urandom;
    set_idle(nxt);
    #1;
    chk({tag, ".idle_err"}, mem_err_out, 1'b0);
    chk({tag, ".idle_req"}, mem_if.proc2mem_req, 1'b0);
    chk({tag, ".idle_pass"}, mem_result_out, nxt);
  endtask

  initial begin
    vec_t rv;
    logic [2:0] f3_tab[5];
    logic mop;

    f3_tab[0] = MEM_BYTE; f3_tab[1] = MEM_HALF; f3_tab[2] = MEM_WORD;
    f3_tab[3] = MEM_BYTEU; f3_tab[4] = MEM_HALFU;

    //         addr          regb          f3      rd    wr    vld   dly word          result        be       data          mis
    vecs[0]  = '{32'h0000_1234, 32'h0,        3'b010, 1'b0, 1'b0, 1'b1, 0,  32'h0,        32'h0000_1234, 4'h0,    32'h0,        1'b0};
    vecs[1]  = '{32'h0000_0103, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 0,  32'h80FF_FFFF, 32'hFFFF_FF80, 4'h0,    32'h0,        1'b0};
    vecs[2]  = '{32'h0000_0103, 32'h0,        3'b100, 1'b1, 1'b0, 1'b1, 0,  32'h80FF_FFFF, 32'h0000_0080, 4'h0,    32'h0,        1'b0};
    vecs[3]  = '{32'h0000_0202, 32'hABCD_1234, 3'b001, 1'b0, 1'b1, 1'b1, 1,  32'h0,        32'h0,        4'b1100, 32'h1234_1234, 1'b0};
    vecs[4]  = '{32'h0000_0101, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 0,  32'h0,        32'h0,        4'h0,    32'h0,        1'b1};
    vecs[5]  = '{32'h0000_0301, 32'h5555_6666, 3'b001, 1'b0, 1'b1, 1'b1, 0,  32'h0,        32'h0,        4'h0,    32'h0,        1'b1};
    vecs[6]  = '{32'h0000_0100, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 20, 32'h0,        32'hbaad_beef, 4'h0,    32'h0,        1'b0};
    vecs[7]  = '{32'h0000_0102, 32'h0,        3'b001, 1'b1, 1'b0, 1'b1, 2,  32'h8001_7FFF, 32'hFFFF_8001, 4'h0,    32'h0,        1'b0};
    vecs[8]  = '{32'h0000_0102, 32'h0,        3'b101, 1'b1, 1'b0, 1'b1, 3,  32'h8001_7FFF, 32'h0000_8001, 4'h0,    32'h0,        1'b0};
    vecs[9]  = '{32'h0000_0101, 32'h0000_0055, 3'b000, 1'b0, 1'b1, 1'b1, 0,  32'h0,        32'h0,        4'b0010, 32'h5555_5555, 1'b0};
    vecs[10] = '{32'h0000_010C, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b1, 1'b1, 4,  32'h0,        32'h0,        4'b1111, 32'hDEAD_BEEF, 1'b0};
    vecs[11] = '{32'h0000_0444, 32'h0,        3'b010, 1'b1, 1'b1, 1'b0, 0,  32'h0,        32'h0000_0444, 4'h0,    32'h0,        1'b0};
    vecs[12] = '{32'h0000_0200, 32'h9999_9999, 3'b010, 1'b1, 1'b1, 1'b1, 0,  32'h1122_3344, 32'h1122_3344, 4'h0,    32'h0,        1'b0};
    vecs[13] = '{32'h0000_0101, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 1,  32'h0000_7F00, 32'h0000_007F, 4'h0,    32'h0,        1'b0};

    rst = 1'b1;
    set_idle(32'h0);
    mem_if.mem2proc_ack  = 1'b0;
    mem_if.mem2proc_data = 32'h0;
    step();
    step();
    chk("rst.req", mem_if.proc2mem_req, 1'b0);
    chk("rst.stall", mem_stall_out, 1'b0);
    chk("rst.err", mem_err_out, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst.req", mem_if.proc2mem_req, 1'b0);
    chk("post_rst.we", mem_if.proc2mem_we, 1'b0);
    chk("post_rst.addr", mem_if.proc2mem_addr, 32'h0);
    chk("post_rst.data", mem_if.proc2mem_data, 32'h0);
    chk("post_rst.be", mem_if.proc2mem_be, 4'h0);
    chk("post_rst.result", mem_result_out, 32'h0);
    chk("post_rst.mis", mem_misaligned_out, 1'b0);
    chk("post_rst.err", mem_err_out, 1'b0);

    for (int i = 0; i < 14; i++) do_access($sformatf("vec%0d", i), vecs[i]);

    // Reset while an access is outstanding; a late ack must be ignored.
    ex_mem_alu_result = 32'h0000_0400;
    ex_mem_funct3     = MEM_WORD;
    ex_mem_rd_mem     = 1'b1;
    ex_mem_wr_mem     = 1'b0;
    ex_mem_valid_inst = 1'b1;
    step();
    chk("rstbusy.req_before", mem_if.proc2mem_req, 1'b1);
    rst = 1'b1;
    step();
    set_idle(32'h0000_0055);
    #1;
    chk("rstbusy.req_dropped", mem_if.proc2mem_req, 1'b0);
    chk("rstbusy.stall", mem_stall_out, 1'b0);
    chk("rstbusy.pass", mem_result_out, 32'h0000_0055);
    rst = 1'b0;
    mem_if.mem2proc_ack  = 1'b1;
    mem_if.mem2proc_data = 32'h1234_5678;
    step();
    mem_if.mem2proc_ack = 1'b0;
    #1;
    chk("rstbusy.late_ack_req", mem_if.proc2mem_req, 1'b0);
    chk("rstbusy.late_ack_err", mem_err_out, 1'b0);
    chk("rstbusy.late_ack_pass", mem_result_out, 32'h0000_0055);
    step();
    chk("rstbusy.still_idle", mem_if.proc2mem_req, 1'b0);

    for (int r = 0; r < 40; r++) begin
      rv.f3        = f3_tab[$urandom_range(0, 4)];
      rv.addr      = $urandom;
      rv.regb      = $urandom;
      rv.word      = $urandom;
      rv.rd        = 1'($urandom_range(0, 1));
      rv.wr        = 1'($urandom_range(0, 1));
      rv.valid     = ($urandom_range(0, 7) != 0);
      rv.ack_delay = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      mop          = rv.valid & (rv.rd | rv.wr);
      rv.exp_mis   = mop & m_mis(rv.addr, rv.f3);
      rv.exp_be    = m_be(rv.addr, rv.f3);
      rv.exp_data  = m_data(rv.regb, rv.f3);
      if (!mop)         rv.exp_result = rv.addr;
      else if (rv.rd)   rv.exp_result = m_load(rv.word, rv.addr, rv.f3);
      else              rv.exp_result = 32'h0;
      do_access($sformatf("rand%0d", r), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result (used as the effective address) and the register-B value (used as store data).
- Runs a req/ack handshake with data memory, aligns and sign-extends load data, and stalls upstream while an access is outstanding.
- Non-memory instructions pass the ALU result straight through.

Parameters:
- MEM_TIMEOUT, default 16: maximum BUSY cycles to wait for mem2proc_ack before aborting the access.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ex_mem_alu_result  in  32  ALU result / effective address
- ex_mem_regb  in  32  store data (rs2)
- ex_mem_funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_mem_rd_mem  in  1  load instruction
- ex_mem_wr_mem  in  1  store instruction
- ex_mem_valid_inst  in  1  instruction valid
- mem2proc_ack  in  1  memory has completed the access
- mem2proc_data  in  32  word-aligned read data
- proc2mem_req  out  1  access request (registered)
- proc2mem_we  out  1  1 = store
- proc2mem_addr  out  32  word address, {addr[31:2], 2'b00}
- proc2mem_data  out  32  lane-replicated store data
- proc2mem_be  out  4  byte enables
- mem_result_out  out  32  writeback value
- mem_stall_out  out  1  hold the upstream pipeline
- mem_misaligned_out  out  1  misaligned access detected
- mem_err_out  out  1  one-cycle timeout pulse

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset:
  - state=IDLE, timeout counter=0, latched address/data/be/we/funct3=0, load result register=0.
  - All outputs are 0 during reset and in the first cycle after it, unless inputs request otherwise.
- Memory op definition: mem_op = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem). If rd and wr are both set, the access is a load.
- Misalignment:
  - H/HU is misaligned when addr[0]=1.
  - W is misaligned when addr[1:0]!=0.
  - B/BU is never misaligned.
- IDLE, not mem_op:
  - mem_result_out = ex_mem_alu_result (combinational), stall=0.
  - No request is issued.
- IDLE, mem_op and misaligned:
  - mem_misaligned_out=1 (combinational), mem_result_out=0, stall=0.
  - No request; state stays IDLE.
- IDLE, mem_op and aligned:
  - Latch addr, we, be, data and funct3.
  - mem_stall_out=1 this cycle; next state BUSY.
- BUSY:
  - proc2mem_req=1 and stall=1; address, data, be and we come from the latched values and stay stable.
  - Counter increments each cycle.
  - On mem2proc_ack: for a load, capture the aligned/extended data; for a store, capture 0. Next state DONE.
  - If the counter reaches MEM_TIMEOUT-1 without ack: capture 32'hbaadbeef, pulse mem_err_out for one cycle, next state DONE.
- DONE:
  - req=0, stall=0, mem_result_out = captured value.
  - Unconditional transition to IDLE. The inputs are still the same held instruction and must not restart an access.
- Latency: access issued at cycle t; ack at t+1 gives result at t+2. Stall is high for 1+N cycles, where N is the number of BUSY cycles.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0], data = {4{regb[7:0]}}.
  - SH: be = 4'b0011 << addr[1:0], data = {2{regb[15:0]}}.
  - SW: be = 4'b1111, data = regb.
- Load extraction:
  - Select the byte/half lane with latched addr[1:0].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- Ignored or invalidated inputs:
  - mem2proc_ack in IDLE or DONE is ignored.
  - A late ack after reset is ignored.
  - rst in BUSY drops req on the next edge and discards the access.
  - ex_mem_valid_inst=0 suppresses any request regardless of rd/wr.

Decomposition:
- sys_defs.vh gets:
  - `MEM_BYTE, `MEM_HALF, `MEM_WORD, `MEM_BYTEU, `MEM_HALFU (funct3 encodings)
  - the mem-stage state enum typedef
  - `MEM_ERR_VAL = 32'hbaadbeef
- One combinational sub-module, mem_load_align: inputs word, addr[1:0], funct3; output 32-bit extended result.

Test Plan:
- Non-mem op, alu_result=32'h1234 -> mem_result_out=32'h1234 same cycle; req never asserted; stall=0.
- LB addr=32'h103, ack on first BUSY cycle with mem2proc_data=32'h80FF_FFFF:
  - proc2mem_addr=32'h100, stall high for 2 cycles.
  - DONE result=32'hFFFF_FF80; with LBU the result is 32'h0000_0080.
- SH addr=32'h202, regb=32'hABCD_1234 -> we=1, be=4'b1100, data=32'h1234_1234, addr=32'h200; DONE result=0.
- LW addr=32'h101 -> mem_misaligned_out=1, req stays 0, stall=0; SH addr=32'h301 gives the same response.
- LW with no ack and MEM_TIMEOUT=16 -> req high for 16 cycles, mem_err_out one-cycle pulse, result 32'hbaadbeef, then IDLE.
- rst asserted during BUSY, then ack arrives -> req=0 on the next cycle, state IDLE, ack ignored, result register 0.
